// File: rtl/iis_pkg.sv
// rtl/iis_pkg.sv - shared constants and stereo frame type for the I2S frame path
// Purpose: default channel width, default FIFO depth and the {left, right} frame record.
// Ports: none.
package iis_pkg;

    localparam int IIS_DATA_W     = 24;
    localparam int IIS_FIFO_DEPTH = 16;

    typedef struct packed {
        logic [IIS_DATA_W-1:0] left;
        logic [IIS_DATA_W-1:0] right;
    } iis_frame_t;

endpackage

// File: rtl/iis_frame_fifo_if.sv
// rtl/iis_frame_fifo_if.sv - show-ahead stereo frame output handshake
// Purpose: groups the head-frame valid/ready handshake and its two channel words.
// Ports (master = FIFO side):
//   frame_valid  master->slave  head frame is available
//   frame_ready  slave->master  consumer accepts the head frame
//   ldata_o      master->slave  head-frame left word
//   rdata_o      master->slave  head-frame right word
interface iis_frame_fifo_if
    import iis_pkg::*;
#(
    parameter int DATA_W = IIS_DATA_W
) ();

    logic              frame_valid;
    logic              frame_ready;
    logic [DATA_W-1:0] ldata_o;
    logic [DATA_W-1:0] rdata_o;

    modport master (
        output frame_valid,
        output ldata_o,
        output rdata_o,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  ldata_o,
        input  rdata_o,
        output frame_ready
    );

endinterface

// File: rtl/iis_frame_ram.sv
// rtl/iis_frame_ram.sv - simple dual-port frame storage, synchronous write, asynchronous read
// Purpose: DEPTH x WIDTH array without reset.
// Ports:
//   clk_i    write clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from raddr_i)
module iis_frame_ram #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iis_frame_fifo.sv
// rtl/iis_frame_fifo.sv - captures stereo I2S frames on lrclk falls into a show-ahead FIFO
// Purpose: one {left, right} frame is written per completed L/R pair; the head frame is
//          presented on frame_if with valid/ready handshake.
// Ports:
//   clk_100m  system clock
//   rst_n     asynchronous active-low reset
//   en        capture enable
//   lrclk     word select, synchronous to clk_100m
//   ldata_i   left word to capture
//   rdata_i   right word to capture
//   frame_if  head-frame handshake (master)
//   level     number of stored frames
//   overflow  sticky: a frame was dropped because the FIFO was full
//   clr_ovf   clears overflow
module iis_frame_fifo
    import iis_pkg::*;
#(
    parameter int DATA_W = IIS_DATA_W,
    parameter int DEPTH  = IIS_FIFO_DEPTH
) (
    input  logic                   clk_100m,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   lrclk,
    input  logic [DATA_W-1:0]      ldata_i,
    input  logic [DATA_W-1:0]      rdata_i,
    iis_frame_fifo_if.master       frame_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic                lrclk_q;
    logic                armed_q;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [2*DATA_W-1:0] hold_q, hold_d;
    logic                overflow_q, overflow_d;
    logic [2*DATA_W-1:0] rd_word;

    logic cap, empty, full, valid, pop, drop, push;

    // lrclk_q comes out of reset high, so a line already low at release would look like
    // a fall; armed_q keeps the first edge after reset from capturing.
    assign cap   = lrclk_q & ~lrclk & en & armed_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign valid = ~empty;
    assign pop   = valid & frame_if.frame_ready;
    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    assign drop  = cap & full & ~pop;
    assign push  = cap & ~drop;

    iis_frame_ram #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_100m),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({ldata_i, rdata_i}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_word)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        hold_d     = hold_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        // Track the presented head so the outputs keep it once the FIFO drains.
        if (valid) hold_d = rd_word;
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            lrclk_q    <= 1'b1;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            lrclk_q    <= lrclk;
            armed_q    <= 1'b1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    assign level                = wr_ptr_q - rd_ptr_q;
    assign overflow             = overflow_q;
    assign frame_if.frame_valid = valid;
    assign frame_if.ldata_o     = valid ? rd_word[2*DATA_W-1:DATA_W] : hold_q[2*DATA_W-1:DATA_W];
    assign frame_if.rdata_o     = valid ? rd_word[DATA_W-1:0]        : hold_q[DATA_W-1:0];

endmodule
